// File: rtl/if_id_skid_buffer.sv
// if_id_skid_buffer: two-entry elastic buffer between instruction fetch and
// the ID field decoder. Slot0 is the head and slot1 is the tail. if_ready
// depends only on registered occupancy, so ID stalls never reach the fetch
// ready path combinationally. A synchronous flush empties the buffer.
// Optional statistics counters are enabled by defining IFID_STAT_EN.
module if_id_skid_buffer #(
    parameter int                INST_W   = 32,
    parameter int                PC_W     = 32,
    parameter logic [INST_W-1:0] NOP_WORD = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [INST_W-1:0] if_inst,
    input  logic [PC_W-1:0]   if_pc,
    input  logic              if_exc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [INST_W-1:0] id_inst,
    output logic [PC_W-1:0]   id_pc,
    output logic              id_exc,
    output logic [1:0]        count
`ifdef IFID_STAT_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [15:0]       flush_drops
`endif
);

    localparam int ENT_W = INST_W + PC_W + 1;

    logic [ENT_W-1:0] slot0_q, slot0_d;
    logic [ENT_W-1:0] slot1_q, slot1_d;
    logic [1:0]       count_q, count_d;
    logic [ENT_W-1:0] in_ent;
    logic             push, pop;

    assign in_ent   = {if_inst, if_pc, if_exc};
    assign if_ready = (count_q != 2'd2);
    assign id_valid = (count_q != 2'd0);
    assign push     = if_valid & if_ready & ~flush;
    assign pop      = id_valid & id_ready;
    assign count    = count_q;

    // Head presentation: NOP bubble with zero PC/exc whenever empty.
    always_comb begin
        id_inst = NOP_WORD;
        id_pc   = '0;
        id_exc  = 1'b0;
        if (id_valid) begin
            id_inst = slot0_q[ENT_W-1 -: INST_W];
            id_pc   = slot0_q[PC_W:1];
            id_exc  = slot0_q[0];
        end
    end

    // Occupancy and slot next-state; flush overrides push and pop.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            unique case (count_q)
                2'd0: begin
                    if (push) begin
                        slot0_d = in_ent;
                        count_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        slot0_d = in_ent;
                    end else if (push) begin
                        slot1_d = in_ent;
                        count_d = 2'd2;
                    end else if (pop) begin
                        count_d = 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        slot0_d = slot1_q;
                        count_d = 2'd1;
                    end
                end
                default: count_d = 2'd0;
            endcase
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= '0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

`ifdef IFID_STAT_EN
    logic [31:0] stall_q, stall_d;
    logic [15:0] drops_q, drops_d;
    logic [1:0]  drops_add;
    logic [16:0] drops_sum;

    // Drops in a flush cycle are the buffered entries plus any offered word,
    // whether or not the buffer could have accepted it.
    assign drops_add = count_q + {1'b0, if_valid};
    assign drops_sum = {1'b0, drops_q} + {15'b0, drops_add};

    // Saturating statistics next-state.
    always_comb begin
        stall_d = stall_q;
        drops_d = drops_q;
        if (id_valid && !id_ready && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
        if (flush) begin
            drops_d = drops_sum[16] ? '1 : drops_sum[15:0];
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_q <= '0;
            drops_q <= '0;
        end else begin
            stall_q <= stall_d;
            drops_q <= drops_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_drops  = drops_q;
`endif

endmodule

// File: tb/tb_if_id_skid_buffer.sv
// Directed bench for if_id_skid_buffer: a table of per-cycle input/expected
// output records, followed by a hand-written asynchronous reset sequence.
// Optional counters (IFID_STAT_EN) are checked when the macro is defined.
module tb_if_id_skid_buffer;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_exc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_exc;
    logic [1:0]  count;
`ifdef IFID_STAT_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_drops;
`endif

    if_id_skid_buffer #(
        .INST_W  (32),
        .PC_W    (32),
        .NOP_WORD(32'h0000_0000)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .flush   (flush),
        .if_valid(if_valid),
        .if_ready(if_ready),
        .if_inst (if_inst),
        .if_pc   (if_pc),
        .if_exc  (if_exc),
        .id_valid(id_valid),
        .id_ready(id_ready),
        .id_inst (id_inst),
        .id_pc   (id_pc),
        .id_exc  (id_exc),
        .count   (count)
`ifdef IFID_STAT_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_drops (flush_drops)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row = inputs driven for a cycle plus the outputs expected during
    // that same cycle (i.e. the state left by the previous edge).
    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        exc;
        logic        idr;
        logic        e_valid;
        logic        e_ready;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic        e_exc;
        logic [1:0]  e_count;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_err;
    int   m_stall;
    int   m_drops;

    function automatic vec_t mk(logic fl, logic iv, logic [31:0] inst, logic [31:0] pc,
                                logic exc, logic idr, logic ev, logic er,
                                logic [31:0] ei, logic [31:0] ep, logic ee, logic [1:0] ec);
        vec_t v;
        v.fl = fl; v.iv = iv; v.inst = inst; v.pc = pc; v.exc = exc; v.idr = idr;
        v.e_valid = ev; v.e_ready = er; v.e_inst = ei; v.e_pc = ep; v.e_exc = ee;
        v.e_count = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ev, input logic er,
                              input logic [31:0] ei, input logic [31:0] ep,
                              input logic ee, input logic [1:0] ec);
        check({tag, ".id_valid"}, {31'b0, id_valid}, {31'b0, ev});
        check({tag, ".if_ready"}, {31'b0, if_ready}, {31'b0, er});
        check({tag, ".id_inst"},  id_inst, ei);
        check({tag, ".id_pc"},    id_pc, ep);
        check({tag, ".id_exc"},   {31'b0, id_exc}, {31'b0, ee});
        check({tag, ".count"},    {30'b0, count}, {30'b0, ec});
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        m_stall = 0;
        m_drops = 0;

        // Reset / single push.
        vecs.push_back(mk(0, 0, 32'h0, 32'h0, 0, 1,   0, 1, 32'h0, 32'h0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h2402_0005, 32'hBFC0_0000, 0, 1,
                          0, 1, 32'h0, 32'h0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0, 32'h0, 0, 1,
                          1, 1, 32'h2402_0005, 32'hBFC0_0000, 0, 1));
        vecs.push_back(mk(0, 0, 32'h0, 32'h0, 0, 1,   0, 1, 32'h0, 32'h0, 0, 0));
        // Backpressure: A, B accepted, C held until room.
        vecs.push_back(mk(0, 1, 32'h1111_0001, 32'h100, 0, 0,  0, 1, 32'h0, 32'h0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h1111_0002, 32'h104, 0, 0,
                          1, 1, 32'h1111_0001, 32'h100, 0, 1));
        vecs.push_back(mk(0, 1, 32'h1111_0003, 32'h108, 0, 0,
                          1, 0, 32'h1111_0001, 32'h100, 0, 2));
        vecs.push_back(mk(0, 1, 32'h1111_0003, 32'h108, 0, 1,
                          1, 0, 32'h1111_0001, 32'h100, 0, 2));
        vecs.push_back(mk(0, 1, 32'h1111_0003, 32'h108, 0, 1,
                          1, 1, 32'h1111_0002, 32'h104, 0, 1));
        vecs.push_back(mk(0, 0, 32'h0, 32'h0, 0, 1,
                          1, 1, 32'h1111_0003, 32'h108, 0, 1));
        vecs.push_back(mk(0, 0, 32'h0, 32'h0, 0, 1,   0, 1, 32'h0, 32'h0, 0, 0));
        // Streaming 8 words: occupancy stays at 1, one-cycle latency.
        for (int k = 0; k < 8; k++) begin
            if (k == 0)
                vecs.push_back(mk(0, 1, 32'h2000_0000, 32'h400, 0, 1,
                                  0, 1, 32'h0, 32'h0, 0, 0));
            else
                vecs.push_back(mk(0, 1, 32'h2000_0000 + k, 32'h400 + 4 * k, 0, 1,
                                  1, 1, 32'h2000_0000 + k - 1, 32'h400 + 4 * (k - 1), 0, 1));
        end
        vecs.push_back(mk(0, 0, 32'h0, 32'h0, 0, 1,
                          1, 1, 32'h2000_0007, 32'h41C, 0, 1));
        vecs.push_back(mk(0, 0, 32'h0, 32'h0, 0, 1,   0, 1, 32'h0, 32'h0, 0, 0));
        // Exception flag travels with its own word only.
        vecs.push_back(mk(0, 1, 32'h3000_0000, 32'h200, 0, 1,  0, 1, 32'h0, 32'h0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h3000_0001, 32'h204, 1, 1,
                          1, 1, 32'h3000_0000, 32'h200, 0, 1));
        vecs.push_back(mk(0, 1, 32'h3000_0002, 32'h208, 0, 1,
                          1, 1, 32'h3000_0001, 32'h204, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0, 32'h0, 0, 1,
                          1, 1, 32'h3000_0002, 32'h208, 0, 1));
        vecs.push_back(mk(0, 0, 32'h0, 32'h0, 0, 1,   0, 1, 32'h0, 32'h0, 0, 0));
        // Flush with count 2 and a word offered: old head visible, then empty.
        vecs.push_back(mk(0, 1, 32'h4000_0000, 32'h300, 0, 0,  0, 1, 32'h0, 32'h0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h4000_0001, 32'h304, 0, 0,
                          1, 1, 32'h4000_0000, 32'h300, 0, 1));
        vecs.push_back(mk(1, 1, 32'h4000_0002, 32'h308, 0, 0,
                          1, 0, 32'h4000_0000, 32'h300, 0, 2));
        vecs.push_back(mk(0, 0, 32'h0, 32'h0, 0, 1,   0, 1, 32'h0, 32'h0, 0, 0));
        // Flush beats push & pop with count 1.
        vecs.push_back(mk(0, 1, 32'h5000_0000, 32'h500, 0, 1,  0, 1, 32'h0, 32'h0, 0, 0));
        vecs.push_back(mk(1, 1, 32'h5000_0001, 32'h504, 0, 1,
                          1, 1, 32'h5000_0000, 32'h500, 0, 1));
        vecs.push_back(mk(0, 0, 32'h0, 32'h0, 0, 1,   0, 1, 32'h0, 32'h0, 0, 0));
        // Flush while empty drops the offered word.
        vecs.push_back(mk(1, 1, 32'h6000_0000, 32'h600, 1, 1,  0, 1, 32'h0, 32'h0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0, 32'h0, 0, 1,   0, 1, 32'h0, 32'h0, 0, 0));

        resetn   = 1'b0;
        flush    = 1'b0;
        if_valid = 1'b0;
        if_inst  = '0;
        if_pc    = '0;
        if_exc   = 1'b0;
        id_ready = 1'b0;

        #2;
        n_vec++;
        check_outs("in_reset", 0, 1, 32'h0, 32'h0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            flush    = vecs[i].fl;
            if_valid = vecs[i].iv;
            if_inst  = vecs[i].inst;
            if_pc    = vecs[i].pc;
            if_exc   = vecs[i].exc;
            id_ready = vecs[i].idr;
            n_vec++;
            check_outs($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_ready,
                       vecs[i].e_inst, vecs[i].e_pc, vecs[i].e_exc, vecs[i].e_count);
            if (vecs[i].e_valid && !vecs[i].idr) m_stall++;
            if (vecs[i].fl) m_drops += int'(vecs[i].e_count) + int'(vecs[i].iv);
            @(posedge clk);
            #1;
        end

`ifdef IFID_STAT_EN
        n_vec++;
        check("stall_cycles", stall_cycles, m_stall);
        check("flush_drops", {16'b0, flush_drops}, m_drops);
`endif

        // Asynchronous reset with two words buffered.
        flush    = 1'b0;
        id_ready = 1'b0;
        if_valid = 1'b1;
        if_inst  = 32'h7000_0000;
        if_pc    = 32'h700;
        if_exc   = 1'b1;
        @(posedge clk);
        #1;
        if_inst  = 32'h7000_0001;
        if_pc    = 32'h704;
        if_exc   = 1'b0;
        @(posedge clk);
        #1;
        if_valid = 1'b0;
        n_vec++;
        check_outs("full_pre_reset", 1, 0, 32'h7000_0000, 32'h700, 1, 2);
        #2;
        resetn = 1'b0;
        #1;
        n_vec++;
        check_outs("async_reset", 0, 1, 32'h0, 32'h0, 0, 0);
`ifdef IFID_STAT_EN
        check("stall_rst", stall_cycles, 32'h0);
        check("drops_rst", {16'b0, flush_drops}, 32'h0);
`endif
        @(negedge clk);
        resetn   = 1'b1;
        id_ready = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        check_outs("post_reset", 0, 1, 32'h0, 32'h0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_id_skid_buffer.md
Name: if_id_skid_buffer

Overview:
- Two-entry elastic buffer between the instruction-fetch stage and the ID stage field decoder.
- Accepts fetched instruction words with their PC and fetch-exception flag over a valid/ready handshake.
- Presents them in order to the ID stage. Decouples the fetch ready path from ID stalls.
- Supports a synchronous pipeline flush on branch redirect or exception.

Parameters:
- INST_W, 32, instruction word width.
- PC_W, 32, program counter width.
- NOP_WORD, 32'h0000_0000, value driven on id_inst whenever the buffer is empty (MIPS sll $0,$0,0).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- resetn  input  1  asynchronous active-low reset.
- flush  input  1  synchronous discard of all buffered and incoming entries.
- if_valid  input  1  fetch stage presents a word.
- if_ready  output  1  buffer can accept a word this cycle.
- if_inst  input  INST_W  fetched instruction.
- if_pc  input  PC_W  PC of the fetched instruction.
- if_exc  input  1  fetch address error / TLB fault flag for this word.
- id_valid  output  1  head entry valid toward ID.
- id_ready  input  1  ID stage consumes the head this cycle.
- id_inst  output  INST_W  head instruction (feeds ID field decode).
- id_pc  output  PC_W  head PC.
- id_exc  output  1  head fetch-exception flag.
- count  output  2  occupancy, 0..2.

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Storage: two entries, slot0 = head, slot1 = tail. Each entry holds {inst, pc, exc}. count is a registered occupancy.
- if_ready = (count != 2). Combinational from registered state only; no dependence on id_ready.
- push = if_valid & if_ready & ~flush. pop = id_valid & id_ready.
- id_valid = (count != 0).
  - When count == 0: id_inst = NOP_WORD, id_pc = 0, id_exc = 0.
  - Otherwise: id_* = slot0 registers.
- Latency: a word pushed in cycle N is visible on id_* in cycle N+1 when the buffer was empty. There is no same-cycle bypass.
- Throughput: 1 word/cycle sustained with count == 1 and push & pop every cycle.
- Next-state table (no flush):
  - count 0, push: slot0 <= in; count 1.
  - count 1, push only: slot1 <= in; count 2.
  - count 1, pop only: count 0.
  - count 1, push & pop: slot0 <= in; count 1.
  - count 2, pop: slot0 <= slot1; count 1. Push is impossible because if_ready = 0.
  - count 2, no pop: hold.
  - No push & no pop: hold.
- Flush has priority over push and pop:
  - count <= 0 next cycle; slot contents are don't-care.
  - A word offered in the flush cycle is dropped.
  - id_valid is low from the cycle after flush.
  - id_* still show the old head during the flush cycle. ID must qualify with flush.
- Order: strict FIFO. Entries are never reordered or duplicated. The exc flag travels with its word unchanged.
- Reset (asynchronous assert, synchronous deassert handled externally):
  - count = 0, id_valid = 0, if_ready = 1 in the first cycle after release.
  - id_inst = NOP_WORD, id_pc = 0, id_exc = 0.
  - Slot registers cleared to 0.
- Reset mid-operation: all buffered words are lost. No output glitch other than the immediate drop to reset values.
- Inputs are ignored while if_ready = 0. Fetch must hold if_* stable until accepted; the buffer does not check this.

Optional Feature:
- Macro IFID_STAT_EN.
- When defined, adds two outputs:
  - stall_cycles (32): increments each cycle with id_valid & ~id_ready; saturates at 32'hFFFF_FFFF.
  - flush_drops (16): on each flush cycle, adds the number of entries discarded, i.e. count plus 1 if if_valid was high; saturates at 16'hFFFF.
- Both counters reset to 0 on resetn.
- When the macro is undefined, the ports and logic are absent and the behaviour is otherwise identical.

Test Plan:
- Reset, then idle -> id_valid = 0, id_inst = 32'h0, count = 0, if_ready = 1.
- Push 0x2402_0005 @ PC 0xBFC0_0000 with id_ready = 1 -> cycle+1: id_valid = 1, id_inst = 0x2402_0005, id_pc = 0xBFC0_0000. Next cycle: count = 0.
- id_ready = 0, push A, B, C back-to-back -> A and B accepted, count = 2, if_ready = 0, C held. Raise id_ready -> outputs A, B, C in order on successive cycles, no gaps after the first.
- Streaming: 8 words with if_valid = id_ready = 1 continuously -> count stays 1; outputs match inputs one cycle later.
- count = 2 plus a same-cycle push offer, assert flush -> next cycle count = 0, id_valid = 0. With IFID_STAT_EN, flush_drops increases by 3.
- Push a word with if_exc = 1 between two clean words -> id_exc = 1 only for that word's PC.
- Assert resetn = 0 asynchronously mid-stream with count = 2 -> outputs go to reset values before the next clk edge.
